// File: rtl/demux_frame_sequencer.sv
// Serialises channel-tagged frames MSB first for the 1-to-8 demux,
// inserts an idle gap after each frame and counts completed frames.
module demux_frame_sequencer #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_chan,
  input  logic [DATA_W-1:0] in_data,
  output logic [2:0]        sel,
  output logic              din,
  output logic              bit_strobe,
  output logic              frame_done,
  output logic              busy,
  input  logic [2:0]        cnt_sel,
  output logic [7:0]        cnt_out
);

  localparam int IW = $clog2(DATA_W);
  localparam logic [IW-1:0] IDX_TOP = IW'(DATA_W - 1);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);
  localparam logic [3:0] GAP_LAST =
    4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t            state_q;
  logic [2:0]        sel_q;
  logic              din_q;
  logic              strobe_q;
  logic              done_q;
  logic [DATA_W-1:0] shreg_q;
  logic [IW-1:0]     idx_q;
  logic [3:0]        gap_q;
  logic [7:0]        cnt_q [8];

  assign in_ready   = (state_q == IDLE) && !rst;
  assign busy       = (state_q != IDLE);
  assign sel        = sel_q;
  assign din        = din_q;
  assign bit_strobe = strobe_q;
  assign frame_done = done_q;
  assign cnt_out    = cnt_q[cnt_sel];

  // din/strobe are registered one stage ahead: the MSB leaves on the
  // accept edge, so shreg_q holds only the bits still to be sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      din_q    <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      shreg_q  <= '0;
      idx_q    <= '0;
      gap_q    <= '0;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            sel_q    <= in_chan;
            din_q    <= in_data[DATA_W-1];
            strobe_q <= 1'b1;
            done_q   <= 1'b0;
            shreg_q  <= {in_data[DATA_W-2:0], 1'b0};
            idx_q    <= IDX_TOP;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          if (idx_q != '0) begin
            din_q   <= shreg_q[DATA_W-1];
            shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
            idx_q   <= idx_q - IDX_ONE;
            done_q  <= (idx_q == IDX_ONE);
          end else begin
            din_q        <= 1'b0;
            strobe_q     <= 1'b0;
            done_q       <= 1'b0;
            cnt_q[sel_q] <= cnt_q[sel_q] + 8'd1;
            gap_q        <= GAP_LAST;
            state_q      <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end
        end
        GAP: begin
          if (gap_q == '0) begin
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_frame_sequencer.sv
// Directed bench: default instance plus a DATA_W=4, GAP_CYCLES=0 instance.
module tb_demux_frame_sequencer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_chan;
  logic [7:0] in_data;
  logic [2:0] sel;
  logic       din;
  logic       bit_strobe;
  logic       frame_done;
  logic       busy;
  logic [2:0] cnt_sel;
  logic [7:0] cnt_out;

  logic       v1;
  logic       rdy1;
  logic [2:0] ch1;
  logic [3:0] d1;
  logic [2:0] sel1;
  logic       din1;
  logic       bs1;
  logic       fd1;
  logic       busy1;
  logic [2:0] cs1;
  logic [7:0] co1;

  int errs = 0;
  int checks = 0;

  demux_frame_sequencer u0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_chan(in_chan), .in_data(in_data),
    .sel(sel), .din(din), .bit_strobe(bit_strobe),
    .frame_done(frame_done), .busy(busy),
    .cnt_sel(cnt_sel), .cnt_out(cnt_out)
  );

  demux_frame_sequencer #(.DATA_W(4), .GAP_CYCLES(0)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(v1), .in_ready(rdy1),
    .in_chan(ch1), .in_data(d1),
    .sel(sel1), .din(din1), .bit_strobe(bs1),
    .frame_done(fd1), .busy(busy1),
    .cnt_sel(cs1), .cnt_out(co1)
  );

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] c, input logic [7:0] d);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    in_chan  = c;
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check("send_idle", busy, 1'b0);
  endtask

  initial begin
    logic [7:0] d;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] expc [8];

    rst = 1'b1; in_valid = 1'b0; in_chan = '0; in_data = '0;
    cnt_sel = '0;
    v1 = 1'b0; ch1 = '0; d1 = '0; cs1 = '0;
    tick();
    tick();
    check("rst_rdy", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sel", sel, 3'd0);
    check("rst_strobe", bit_strobe, 1'b0);
    rst = 1'b0;
    #1;
    check("rel_rdy", in_ready, 1'b1);

    // reset during SHIFT aborts the frame
    in_chan = 3'd6; in_data = 8'hF0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("mid_busy", busy, 1'b1);
    check("mid_sel", sel, 3'd6);
    rst = 1'b1;
    cnt_sel = 3'd6;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("r_sel", sel, 3'd0);
      check("r_din", din, 1'b0);
      check("r_strobe", bit_strobe, 1'b0);
      check("r_done", frame_done, 1'b0);
      check("r_busy", busy, 1'b0);
      check("r_rdy", in_ready, 1'b0);
      check("r_cnt6", cnt_out, 8'd0);
    end
    rst = 1'b0;
    #1;
    check("r_rdy_rel", in_ready, 1'b1);
    tick();
    check("r_done2", frame_done, 1'b0);
    check("r_cnt6b", cnt_out, 8'd0);

    // single frame A5 to channel 5
    d = 8'hA5;
    cnt_sel = 3'd5;
    in_chan = 3'd5; in_data = d; in_valid = 1'b1;
    check("sf_rdy", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    in_chan = 3'd2; in_data = 8'h00;
    for (int k = 0; k < 8; k++) begin
      check("sf_sel", sel, 3'd5);
      check("sf_strobe", bit_strobe, 1'b1);
      check("sf_din", din, d[7-k]);
      check("sf_done", frame_done, k == 7);
      if (k == 7) check("sf_cnt_pre", cnt_out, 8'd0);
      tick();
    end
    check("sf_gap_strobe", bit_strobe, 1'b0);
    check("sf_gap_din", din, 1'b0);
    check("sf_gap_sel", sel, 3'd5);
    check("sf_gap_busy", busy, 1'b1);
    check("sf_gap_rdy", in_ready, 1'b0);
    tick();
    check("sf_idle_rdy", in_ready, 1'b1);
    check("sf_cnt", cnt_out, 8'd1);
    check("sf_idle_sel", sel, 3'd5);

    // back-to-back: (0,FF) then (7,01) with in_valid held
    in_chan = 3'd0; in_data = 8'hFF; in_valid = 1'b1;
    tick();
    in_chan = 3'd7; in_data = 8'h01;
    for (int t = 1; t <= 18; t++) begin
      if (t == 11) in_valid = 1'b0;
      check("bb_strobe", bit_strobe,
            (t <= 8) || (t >= 11));
      check("bb_sel", sel, (t <= 10) ? 3'd0 : 3'd7);
      check("bb_din", din, (t <= 8) || (t == 18));
      check("bb_done", frame_done, (t == 8) || (t == 18));
      check("bb_rdy", in_ready, t == 10);
      tick();
    end
    tick();
    check("bb_idle", busy, 1'b0);

    // stall: pulse in_valid to channel 3 mid-frame
    d = 8'h3C;
    in_chan = 3'd1; in_data = d; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        in_valid = 1'b1; in_chan = 3'd3; in_data = 8'hFF;
        check("st_rdy", in_ready, 1'b0);
      end
      if (k == 3) in_valid = 1'b0;
      check("st_din", din, d[7-k]);
      check("st_sel", sel, 3'd1);
      tick();
    end
    tick();
    check("st_busy", busy, 1'b0);
    check("st_sel_idle", sel, 3'd1);
    cnt_sel = 3'd3;
    #1;
    check("st_cnt3", cnt_out, 8'd0);
    cnt_sel = 3'd1;
    #1;
    check("st_cnt1", cnt_out, 8'd1);

    // wrap channel 2 counter
    for (int i = 0; i < 255; i++) send(3'd2, 8'(i));
    cnt_sel = 3'd2;
    #1;
    check("wr_255", cnt_out, 8'd255);
    in_chan = 3'd2; in_data = 8'h81; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) begin
        check("wr_done", frame_done, 1'b1);
        check("wr_pre", cnt_out, 8'd255);
      end
      tick();
    end
    check("wr_zero", cnt_out, 8'd0);
    tick();

    expc = '{8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1};
    for (int c = 0; c < 8; c++) begin
      cnt_sel = 3'(c);
      #1;
      check($sformatf("cnt%0d", c), cnt_out, expc[c]);
    end

    // DATA_W=4, GAP_CYCLES=0: 5-cycle period
    a = 4'h9;
    b = 4'h6;
    v1 = 1'b1; ch1 = 3'd4; d1 = a;
    check("p_rdy0", rdy1, 1'b1);
    tick();
    ch1 = 3'd1; d1 = b;
    for (int t = 1; t <= 9; t++) begin
      if (t == 6) v1 = 1'b0;
      check("p_strobe", bs1, t != 5);
      check("p_rdy", rdy1, t == 5);
      check("p_sel", sel1, (t <= 5) ? 3'd4 : 3'd1);
      check("p_done", fd1, (t == 4) || (t == 9));
      if (t <= 4) check("p_din", din1, a[4-t]);
      else if (t == 5) check("p_din", din1, 1'b0);
      else check("p_din", din1, b[9-t]);
      tick();
    end
    check("p_idle", busy1, 1'b0);
    cs1 = 3'd4;
    #1;
    check("p_cnt4", co1, 8'd1);
    cs1 = 3'd1;
    #1;
    check("p_cnt1", co1, 8'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
